// File: rtl/keycode_event_queue.sv
// Turns level changes on the two-slot HID keycode word into press/release events
// held in a show-ahead FIFO, and exports the last fully scanned key pair.
module keycode_event_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [15:0]   keycode,
    input  logic          pop,
    input  logic          clr_overflow,
    output logic          ev_valid,
    output logic [8:0]    ev_data,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [15:0]   keys_now
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REL0   = 3'd1,
        S_REL1   = 3'd2,
        S_PRS0   = 3'd3,
        S_PRS1   = 3'd4,
        S_UPDATE = 3'd5
    } scan_state_t;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // True when key k occupies either slot of the pair.
    function automatic logic key_in_pair(input logic [7:0] k, input logic [15:0] pair);
        return (k == pair[7:0]) || (k == pair[15:8]);
    endfunction

    scan_state_t    state_r, state_s;
    logic [15:0]    kc_q_r, prev_r, cur_r;
    logic           latch_cur_s, update_prev_s;
    logic           push_s;
    logic [8:0]     push_data_s;

    logic [8:0]     mem_r [DEPTH];
    logic [AW-1:0]  rd_ptr_r, wr_ptr_r, rd_next_s, wr_next_s;
    logic [AW:0]    count_r, count_s;
    logic           ev_valid_r, overflow_r;
    logic [8:0]     ev_data_r, ev_data_s;
    logic           pop_ok_s, push_ok_s, drop_s, full_s;

    // Scan FSM: next state and per-slot event generation.
    always_comb begin
        state_s       = state_r;
        latch_cur_s   = 1'b0;
        update_prev_s = 1'b0;
        push_s        = 1'b0;
        push_data_s   = 9'h000;
        case (state_r)
            S_IDLE: begin
                if (kc_q_r != prev_r) begin
                    latch_cur_s = 1'b1;
                    state_s     = S_REL0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REL0: begin
                if ((prev_r[7:0] != 8'h00) && !key_in_pair(prev_r[7:0], cur_r)) begin
                    push_s      = 1'b1;
                    push_data_s = {1'b0, prev_r[7:0]};
                end else begin
                    push_s = 1'b0;
                end
                state_s = S_REL1;
            end
            S_REL1: begin
                if ((prev_r[15:8] != 8'h00) && (prev_r[15:8] != prev_r[7:0]) &&
                    !key_in_pair(prev_r[15:8], cur_r)) begin
                    push_s      = 1'b1;
                    push_data_s = {1'b0, prev_r[15:8]};
                end else begin
                    push_s = 1'b0;
                end
                state_s = S_PRS0;
            end
            S_PRS0: begin
                if ((cur_r[7:0] != 8'h00) && !key_in_pair(cur_r[7:0], prev_r)) begin
                    push_s      = 1'b1;
                    push_data_s = {1'b1, cur_r[7:0]};
                end else begin
                    push_s = 1'b0;
                end
                state_s = S_PRS1;
            end
            S_PRS1: begin
                if ((cur_r[15:8] != 8'h00) && (cur_r[15:8] != cur_r[7:0]) &&
                    !key_in_pair(cur_r[15:8], prev_r)) begin
                    push_s      = 1'b1;
                    push_data_s = {1'b1, cur_r[15:8]};
                end else begin
                    push_s = 1'b0;
                end
                state_s = S_UPDATE;
            end
            S_UPDATE: begin
                update_prev_s = 1'b1;
                state_s       = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // FIFO accept/drop decisions, next pointers, next count and next head word.
    always_comb begin
        pop_ok_s  = pop && (count_r != '0);
        full_s    = (count_r == DEPTH_C);
        push_ok_s = push_s && (!full_s || pop_ok_s);
        drop_s    = push_s && !push_ok_s;

        if (pop_ok_s) begin
            rd_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_next_s = rd_ptr_r;
        end
        if (push_ok_s) begin
            wr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_next_s = wr_ptr_r;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase

        // An entry written this cycle into the new head slot must bypass the memory.
        if (count_s == '0) begin
            ev_data_s = 9'h000;
        end else if (push_ok_s && (rd_next_s == wr_ptr_r)) begin
            ev_data_s = push_data_s;
        end else begin
            ev_data_s = mem_r[rd_next_s];
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kc_q_r     <= 16'h0000;
            prev_r     <= 16'h0000;
            cur_r      <= 16'h0000;
            state_r    <= S_IDLE;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            ev_valid_r <= 1'b0;
            ev_data_r  <= 9'h000;
            overflow_r <= 1'b0;
        end else begin
            kc_q_r     <= keycode;
            state_r    <= state_s;
            if (latch_cur_s) begin
                cur_r <= kc_q_r;
            end
            if (update_prev_s) begin
                prev_r <= cur_r;
            end
            rd_ptr_r   <= rd_next_s;
            wr_ptr_r   <= wr_next_s;
            count_r    <= count_s;
            ev_valid_r <= (count_s != '0);
            ev_data_r  <= ev_data_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (clr_overflow) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Event storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    assign ev_valid = ev_valid_r;
    assign ev_data  = ev_data_r;
    assign count    = count_r;
    assign overflow = overflow_r;
    assign keys_now = prev_r;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Scoreboard bench for keycode_event_queue: a reference scan model queues expected
// events at stimulus time; they are compared as the DUT presents them.
module tb_keycode_event_queue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] keycode;
    logic        pop;
    logic        clr_overflow;
    logic        ev_valid;
    logic [8:0]  ev_data;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] keys_now;

    keycode_event_queue #(.DEPTH(8), .AW(3)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .keycode      (keycode),
        .pop          (pop),
        .clr_overflow (clr_overflow),
        .ev_valid     (ev_valid),
        .ev_data      (ev_data),
        .count        (count),
        .overflow     (overflow),
        .keys_now     (keys_now)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [8:0]  exp_q[$];
    logic [15:0] prev_m;
    int          model_events = 0;
    logic        wrap_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_push(input logic [8:0] ev);
        exp_q.push_back(ev);
        model_events++;
    endtask

    // Reference event list for a snapshot change p -> c.
    task automatic model_scan(input logic [15:0] p, input logic [15:0] c);
        logic [7:0] k;
        for (int s = 0; s < 2; s++) begin
            k = (s == 0) ? p[7:0] : p[15:8];
            if (k != 8'h00 && !(s == 1 && k == p[7:0]) && k != c[7:0] && k != c[15:8])
                model_push({1'b0, k});
        end
        for (int s = 0; s < 2; s++) begin
            k = (s == 0) ? c[7:0] : c[15:8];
            if (k != 8'h00 && !(s == 1 && k == c[7:0]) && k != p[7:0] && k != p[15:8])
                model_push({1'b1, k});
        end
    endtask

    task automatic apply_kc(input logic [15:0] v);
        model_scan(prev_m, v);
        prev_m  = v;
        keycode = v;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && ev_valid; i++) begin
            if (exp_q.size() == 0) begin
                check_eq({tag, "_unexpected"}, 32'(ev_valid), 32'd0);
                break;
            end
            check_eq(tag, 32'(ev_data), 32'(exp_q.pop_front()));
            pop = 1'b1;
            @(posedge clk);
            #1;
            pop = 1'b0;
        end
        check_eq({tag, "_count0"}, 32'(count), 32'd0);
        check_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        pop          = 1'b0;
        clr_overflow = 1'b0;
        keycode      = 16'h0000;
        prev_m       = 16'h0000;
        wrap_done    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_valid", 32'(ev_valid), 32'd0);
        check_eq("rst_data", 32'(ev_data), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_keys", 32'(keys_now), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency of a single press and the snapshot.
        keycode = 16'h0004;
        model_scan(prev_m, 16'h0004);
        prev_m = 16'h0004;
        repeat (4) @(posedge clk);
        #1;
        check_eq("lat_e3_valid", 32'(ev_valid), 32'd0);
        @(posedge clk);
        #1;
        check_eq("lat_e4_valid", 32'(ev_valid), 32'd1);
        check_eq("lat_e4_data", 32'(ev_data), 32'h104);
        check_eq("lat_e4_count", 32'(count), 32'd1);
        @(posedge clk);
        #1;
        check_eq("lat_e5_keys", 32'(keys_now), 32'h0000);
        @(posedge clk);
        #1;
        check_eq("lat_e6_keys", 32'(keys_now), 32'h0004);
        @(posedge clk);
        #1;
        drain("lat");

        // Release plus two presses, then slot swap.
        apply_kc(16'h1A07);
        check_eq("multi_count", 32'(count), 32'd3);
        check_eq("multi_keys", 32'(keys_now), 32'h1A07);
        drain("multi");
        apply_kc(16'h0704);
        drain("to0704");
        apply_kc(16'h0407);
        check_eq("swap_count", 32'(count), 32'd0);
        check_eq("swap_keys", 32'(keys_now), 32'h0407);

        // Fill to DEPTH, then a dropped press.
        apply_kc(16'h0000);
        apply_kc(16'h0506);
        apply_kc(16'h0000);
        apply_kc(16'h0009);
        apply_kc(16'h0000);
        check_eq("fill_count", 32'(count), 32'd8);
        check_eq("fill_ovf", 32'(overflow), 32'd0);
        keycode = 16'h0011;
        prev_m  = 16'h0011;
        repeat (8) @(posedge clk);
        #1;
        check_eq("drop_ovf", 32'(overflow), 32'd1);
        check_eq("drop_count", 32'(count), 32'd8);
        clr_overflow = 1'b1;
        @(posedge clk);
        #1;
        clr_overflow = 1'b0;
        check_eq("clr_ovf", 32'(overflow), 32'd0);

        // Full FIFO: pop on the release push cycle (REL0 at E2).
        keycode = 16'h0000;
        prev_m  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_eq("full_head", 32'(ev_data), 32'(exp_q.pop_front()));
        pop = 1'b1;
        @(posedge clk);
        #1;
        pop = 1'b0;
        exp_q.push_back(9'h011);
        check_eq("fullpp_count", 32'(count), 32'd8);
        check_eq("fullpp_ovf", 32'(overflow), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        drain("fullpp");

        // Empty FIFO: pop on the press push cycle (PRS0 at E4) is ignored.
        keycode = 16'h0012;
        prev_m  = 16'h0012;
        repeat (4) @(posedge clk);
        #1;
        pop = 1'b1;
        @(posedge clk);
        #1;
        pop = 1'b0;
        exp_q.push_back(9'h112);
        check_eq("emptypp_count", 32'(count), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        drain("emptypp");

        // count = 3: pop together with the slot-1 release push (REL1 at E3).
        apply_kc(16'h1314);
        check_eq("c3_count", 32'(count), 32'd3);
        keycode = 16'h0014;
        prev_m  = 16'h0014;
        repeat (3) @(posedge clk);
        #1;
        check_eq("c3_head", 32'(ev_data), 32'(exp_q.pop_front()));
        pop = 1'b1;
        @(posedge clk);
        #1;
        pop = 1'b0;
        exp_q.push_back(9'h013);
        check_eq("c3pp_count", 32'(count), 32'd3);
        check_eq("c3pp_head", 32'(ev_data), 32'(exp_q[0]));
        repeat (4) @(posedge clk);
        #1;

        // Streaming run across several pointer wraps with a random consumer.
        begin
            int start_ev;
            start_ev = model_events;
            fork
                begin
                    for (int n = 0; n < 60 && (model_events - start_ev) < 20; n++) begin
                        logic [7:0] a, b;
                        int ra, rb;
                        ra = $urandom_range(0, 5);
                        rb = $urandom_range(0, 5);
                        a  = (ra == 0) ? 8'h00 : 8'(8'h20 + ra);
                        b  = (rb == 0) ? 8'h00 : 8'(8'h20 + rb);
                        apply_kc({b, a});
                    end
                    wrap_done = 1'b1;
                end
                begin
                    for (int c = 0; c < 3000; c++) begin
                        @(posedge clk);
                        #2;
                        if (ev_valid && $urandom_range(0, 3) != 0) begin
                            if (exp_q.size() == 0) begin
                                check_eq("wrap_unexpected", 32'(ev_valid), 32'd0);
                                pop = 1'b0;
                            end else begin
                                check_eq("wrap_ev", 32'(ev_data), 32'(exp_q.pop_front()));
                                pop = 1'b1;
                            end
                        end else begin
                            pop = 1'b0;
                        end
                        if (wrap_done && !ev_valid) break;
                    end
                    pop = 1'b0;
                end
            join
            check_eq("wrap_drained", 32'(ev_valid), 32'd0);
            check_eq("wrap_left", 32'(exp_q.size()), 32'd0);
            check_eq("wrap_ovf", 32'(overflow), 32'd0);
        end
        @(posedge clk);
        #1;

        // Mid-scan glitch that reverts: only the scanned snapshot's press.
        apply_kc(16'h0000);
        drain("pre_glitch");
        keycode = 16'h0004;
        model_scan(16'h0000, 16'h0004);
        prev_m = 16'h0004;
        repeat (2) @(posedge clk);
        #1;
        keycode = 16'h0005;
        repeat (2) @(posedge clk);
        #1;
        keycode = 16'h0004;
        repeat (5) @(posedge clk);
        #1;
        check_eq("revert_keys", 32'(keys_now), 32'h0004);
        drain("revert");

        // Mid-scan change that sticks: picked up by the following scan.
        keycode = 16'h0006;
        model_scan(16'h0004, 16'h0006);
        repeat (2) @(posedge clk);
        #1;
        keycode = 16'h0005;
        model_scan(16'h0006, 16'h0005);
        prev_m = 16'h0005;
        repeat (13) @(posedge clk);
        #1;
        check_eq("pair_keys", 32'(keys_now), 32'h0005);
        drain("pair");

        // Asynchronous reset in the middle of a scan.
        keycode = 16'h0007;
        repeat (3) @(posedge clk);
        #1;
        check_eq("midscan_count", 32'(count), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("arst_count", 32'(count), 32'd0);
        check_eq("arst_valid", 32'(ev_valid), 32'd0);
        check_eq("arst_data", 32'(ev_data), 32'd0);
        check_eq("arst_ovf", 32'(overflow), 32'd0);
        check_eq("arst_keys", 32'(keys_now), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keycode_event_queue.md
# keycode_event_queue

Consumes the 16-bit keycode word driven by the Nios-written keycode PIO (two 8-bit USB HID key slots) and converts level changes into discrete press/release events. Events are held in a small show-ahead FIFO popped by the game-logic FSM, so the game reacts once per key transition rather than sampling levels. The block also exports the currently held key pair as a stable, scan-aligned snapshot.

## Interface

- DEPTH, 8, FIFO depth in events; power of two, 2..64
- AW, 3, log2(DEPTH)

- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- keycode  in  16  key slots: [7:0] slot 0, [15:8] slot 1; 0x00 = no key
- pop  in  1  consumer acknowledges head event; ignored when ev_valid = 0
- clr_overflow  in  1  clears sticky overflow flag
- ev_valid  out  1  FIFO non-empty; head event on ev_data
- ev_data  out  9  {press(1)/release(0), code[7:0]}
- count  out  AW+1  events currently stored, 0..DEPTH
- overflow  out  1  sticky: an event was dropped because FIFO was full
- keys_now  out  16  last fully scanned keycode snapshot

## Operation

- Input register: kc_q <= keycode every cycle (no other use of raw keycode).
- Registers: prev (16b, last scanned snapshot, drives keys_now), cur (16b, snapshot under scan).
- Scan FSM: IDLE, REL0, REL1, PRS0, PRS1, UPDATE; one cycle per state.
  - IDLE: if kc_q != prev, cur <= kc_q, go REL0; else stay.
  - REL0: push {0, prev[7:0]} if prev[7:0] != 0 and prev[7:0] not in {cur[7:0], cur[15:8]}.
  - REL1: push {0, prev[15:8]} if nonzero, != prev[7:0], and not in cur slots.
  - PRS0: push {1, cur[7:0]} if nonzero and not in {prev[7:0], prev[15:8]}.
  - PRS1: push {1, cur[15:8]} if nonzero, != cur[7:0], and not in prev slots.
  - UPDATE: prev <= cur; go IDLE.
- Releases always precede presses; slot 0 precedes slot 1.
- kc_q changes during a scan are ignored; they are picked up in the next IDLE comparison. Intermediate values that revert before IDLE produce no events.
- A key moving between slots produces no event.
- FIFO: circular buffer, rd/wr pointers AW bits, wrap modulo DEPTH. Show-ahead: ev_data = mem[rd] when count != 0, else 9'h000.
- Push accepted if count < DEPTH, or count == DEPTH with accepted pop in the same cycle. Otherwise the event is dropped and overflow <= 1.
- Pop accepted only when pop && count != 0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- overflow: set wins over clr_overflow in the same cycle.

## Timing

- Reset (async assert, sync-released by system): state IDLE, kc_q = prev = cur = 0, pointers 0, count 0, ev_valid 0, ev_data 0, overflow 0, keys_now 0. FIFO memory contents are don't-care.
- Reset asserted mid-scan aborts the scan. Queued events are lost.
- Latency, with E0 = edge capturing new keycode into kc_q:
  - Slot-0 release: visible after E2.
  - Slot-1 release: visible after E3.
  - Slot-0 press: visible after E4.
  - Slot-1 press: visible after E5.
  - keys_now updates after E6.
- Scan occupancy: 5 cycles (REL0..UPDATE); the earliest next scan latches cur at E7.
- Pop at edge Ep: ev_data shows the next event, or ev_valid drops, immediately after Ep.
- count and ev_valid update on the same edge as the push or pop.

## Test plan

- Reset, then keycode = 0x0004 (A) -> after E4: ev_valid = 1, ev_data = 0x104, count = 1; after E6: keys_now = 0x0004.
- keycode 0x0004 -> 0x1A07, no pops -> events in order: 0x004 (release A), 0x107, 0x11A; count = 3; keys_now = 0x1A07.
- keycode 0x0704 -> 0x0407 (slot swap) -> no events, count unchanged, keys_now = 0x0407.
- Fill FIFO to DEPTH = 8 with pop = 0, then force one more press -> event dropped, overflow = 1, count = 8. Repeat with pop held on the push cycle -> event accepted, count stays 8, overflow unchanged.
- With count = 0, a push and pop in the same cycle -> pop ignored, count = 1. With count = 3, pop and push together -> count = 3, head advances, order preserved across pointer wrap (run 20 events).
- Pulse keycode 0x0004 -> 0x0005 -> 0x0004 within the REL0..PRS1 window of a scan -> only the scanned snapshot's events are emitted; the next IDLE compare yields a consistent release/press pair. Then assert reset_n low mid-scan -> all outputs return to reset values asynchronously.
